// File: rtl/rename.sv
// Single-issue register rename stage: RAT lookup, free-list allocation, sequence ids,
// one registered output slot, reclamation on commit and clean restore on flush.
module rename #(
  parameter int ARFSIZE = 32,
  parameter int PRFSIZE = 64,
  parameter int ID_BITS = 16,
  localparam int AW   = $clog2(ARFSIZE),
  localparam int PW   = $clog2(PRFSIZE),
  localparam int CW   = $clog2(PRFSIZE + 1),
  localparam int SI_W = 80 + 3 * AW,
  localparam int DI_W = SI_W + ID_BITS + 4 * PW + 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SI_W-1:0] si_i,
  input  logic            si_i_valid,
  output logic            si_i_ready,
  output logic [DI_W-1:0] di_o,
  output logic            di_o_valid,
  input  logic            di_i_ready,
  input  logic            commit_i_valid,
  input  logic [AW-1:0]   commit_rd,
  input  logic [PW-1:0]   commit_prd,
  input  logic [PW-1:0]   commit_old_prd,
  input  logic            commit_old_prd_valid,
  input  logic            flush_i
);
  // si_i packing, MSB first: pc[32] fu[4] op[8] rs1 rs2 rs1_valid rs2_valid rd rd_valid imm[32] use_uimm
  localparam int SI_RDV  = 33;
  localparam int SI_RD   = 34;
  localparam int SI_RS2V = 34 + AW;
  localparam int SI_RS1V = 35 + AW;
  localparam int SI_RS2  = 36 + AW;
  localparam int SI_RS1  = 36 + 2 * AW;

  logic [PW-1:0]      rat_preg_q [ARFSIZE];
  logic [ARFSIZE-1:0] rat_ren_q;
  logic [PW-1:0]      fl_q [PRFSIZE];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      fl_count_q, fl_count_d;
  logic [ID_BITS-1:0] id_q, id_d;
  logic [DI_W-1:0]    di_q, di_d;
  logic               di_valid_q, di_valid_d;

  logic [AW-1:0] rs1_s, rs2_s, rd_s;
  logic          rs1_ren_s, rs2_ren_s, need_alloc_s, stall_fl_s, fire_s, pop_s, push_s, commit_clr_s;
  logic [PW-1:0] prd_s, old_prd_s;
  logic          old_prd_valid_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == PW'(PRFSIZE - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign rs1_s = si_i[SI_RS1 +: AW];
  assign rs2_s = si_i[SI_RS2 +: AW];
  assign rd_s  = si_i[SI_RD +: AW];

  // x0 never carries a renamed bit, so the RAT lookup alone already yields 0 for it
  assign rs1_ren_s    = rat_ren_q[rs1_s] && si_i[SI_RS1V] && !si_i[0] && (rs1_s != {AW{1'b0}});
  assign rs2_ren_s    = rat_ren_q[rs2_s] && si_i[SI_RS2V] && (rs2_s != {AW{1'b0}});
  assign need_alloc_s = si_i[SI_RDV] && (rd_s != {AW{1'b0}});
  assign stall_fl_s   = need_alloc_s && (fl_count_q == {CW{1'b0}});
  assign si_i_ready   = !rst && !stall_fl_s && (!di_valid_q || di_i_ready) && !flush_i;
  assign fire_s       = si_i_valid && si_i_ready;
  assign pop_s        = fire_s && need_alloc_s;
  assign push_s       = commit_i_valid && commit_old_prd_valid && !flush_i;
  assign commit_clr_s = commit_i_valid && !flush_i && rat_ren_q[commit_rd]
                        && (rat_preg_q[commit_rd] == commit_prd);

  assign di_o       = di_q;
  assign di_o_valid = di_valid_q;

  // Destination allocation and next-state for the free-list pointers, id and output slot
  always_comb begin
    prd_s           = {PW{1'b0}};
    old_prd_s       = {PW{1'b0}};
    old_prd_valid_s = 1'b0;
    head_d          = head_q;
    tail_d          = tail_q;
    fl_count_d      = fl_count_q;
    id_d            = id_q;
    di_d            = di_q;
    di_valid_d      = di_valid_q;
    if (need_alloc_s) begin
      prd_s           = fl_q[head_q];
      old_prd_s       = rat_preg_q[rd_s];
      old_prd_valid_s = rat_ren_q[rd_s];
    end else begin
      prd_s           = {PW{1'b0}};
      old_prd_s       = {PW{1'b0}};
      old_prd_valid_s = 1'b0;
    end
    if (flush_i) begin
      head_d     = {PW{1'b0}};
      tail_d     = {PW{1'b0}};
      fl_count_d = CW'(PRFSIZE);
      di_valid_d = 1'b0;
    end else begin
      head_d = pop_s  ? wrap_inc(head_q) : head_q;
      tail_d = push_s ? wrap_inc(tail_q) : tail_q;
      case ({push_s, pop_s})
        2'b10:   fl_count_d = fl_count_q + CW'(1);
        2'b01:   fl_count_d = fl_count_q - CW'(1);
        default: fl_count_d = fl_count_q;
      endcase
      if (fire_s) begin
        di_d       = {si_i, id_q, rat_preg_q[rs1_s], rat_preg_q[rs2_s], rs1_ren_s, rs2_ren_s,
                      prd_s, old_prd_s, old_prd_valid_s};
        di_valid_d = 1'b1;
        id_d       = id_q + ID_BITS'(1);
      end else if (di_i_ready) begin
        di_valid_d = 1'b0;
      end else begin
        di_valid_d = di_valid_q;
      end
    end
  end

  // Pointer, counter, id and output-slot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      fl_count_q <= CW'(PRFSIZE);
      id_q       <= {ID_BITS{1'b0}};
      di_q       <= {DI_W{1'b0}};
      di_valid_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fl_count_q <= fl_count_d;
      id_q       <= id_d;
      di_q       <= di_d;
      di_valid_q <= di_valid_d;
    end
  end

  // RAT: commit clear is issued first so a same-cycle rename write to that areg wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rat_ren_q <= {ARFSIZE{1'b0}};
      for (int i = 0; i < ARFSIZE; i++) rat_preg_q[i] <= {PW{1'b0}};
    end else if (flush_i) begin
      rat_ren_q <= {ARFSIZE{1'b0}};
    end else begin
      if (commit_clr_s) rat_ren_q[commit_rd] <= 1'b0;
      if (pop_s) begin
        rat_preg_q[rd_s] <= prd_s;
        rat_ren_q[rd_s]  <= 1'b1;
      end
    end
  end

  // Free-list storage; reset and flush refill it with 0..PRFSIZE-1 in order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PRFSIZE; i++) fl_q[i] <= PW'(i);
    end else if (flush_i) begin
      for (int i = 0; i < PRFSIZE; i++) fl_q[i] <= PW'(i);
    end else if (push_s) begin
      fl_q[tail_q] <= commit_old_prd;
    end
  end

  rename_chk #(.PRFSIZE(PRFSIZE), .CW(CW)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .count_i (fl_count_q),
    .push_i  (push_s),
    .pop_i   (pop_s)
  );
endmodule

// Free-list occupancy checker: a push into a full list without a pop is an overflow.
module rename_chk #(
  parameter int PRFSIZE = 64,
  parameter int CW      = 7
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] count_i,
  input logic          push_i,
  input logic          pop_i
);
  ap_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && (count_i == CW'(PRFSIZE))));
endmodule

// File: tb/tb_rename.sv
// Directed bench for rename: hand-computed expectations for allocation, stalls, commit and flush.
module tb_rename;
  localparam int AW = 5, PW = 6, ID_BITS = 16;
  localparam int SI_W = 95, DI_W = 138;
  localparam int D_OPV = 0, D_OPRD = 1, D_PRD = 7, D_R2 = 13, D_R1 = 14;
  localparam int D_PRS2 = 15, D_PRS1 = 21, D_ID = 27;

  logic            clk = 1'b0;
  logic            rst;
  logic [SI_W-1:0] si_i;
  logic            si_i_valid, si_i_ready;
  logic [DI_W-1:0] di_o, held;
  logic            di_o_valid, di_i_ready;
  logic            commit_i_valid, commit_old_prd_valid, flush_i;
  logic [AW-1:0]   commit_rd;
  logic [PW-1:0]   commit_prd, commit_old_prd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rename dut (
    .clk(clk), .rst(rst), .si_i(si_i), .si_i_valid(si_i_valid), .si_i_ready(si_i_ready),
    .di_o(di_o), .di_o_valid(di_o_valid), .di_i_ready(di_i_ready),
    .commit_i_valid(commit_i_valid), .commit_rd(commit_rd), .commit_prd(commit_prd),
    .commit_old_prd(commit_old_prd), .commit_old_prd_valid(commit_old_prd_valid),
    .flush_i(flush_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SI_W-1:0] mk_si(input logic [AW-1:0] rs1, input logic rs1v,
                                             input logic [AW-1:0] rs2, input logic rs2v,
                                             input logic [AW-1:0] rd, input logic rdv,
                                             input logic uimm);
    return {32'h0000_1000, 4'h1, 8'h13, rs1, rs2, rs1v, rs2v, rd, rdv, 32'h0000_0001, uimm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    si_i = '0; si_i_valid = 1'b0; di_i_ready = 1'b1; flush_i = 1'b0;
    commit_i_valid = 1'b0; commit_rd = '0; commit_prd = '0;
    commit_old_prd = '0; commit_old_prd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [PW-1:0] f_prd();     return di_o[D_PRD +: PW];  endfunction
  function automatic logic [PW-1:0] f_oprd();    return di_o[D_OPRD +: PW]; endfunction
  function automatic logic [PW-1:0] f_prs1();    return di_o[D_PRS1 +: PW]; endfunction
  function automatic logic [PW-1:0] f_prs2();    return di_o[D_PRS2 +: PW]; endfunction
  function automatic logic [ID_BITS-1:0] f_id(); return di_o[D_ID +: ID_BITS]; endfunction

  initial begin
    // Reset state, observed while rst is still asserted
    rst = 1'b1;
    si_i = mk_si(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); si_i_valid = 1'b1;
    di_i_ready = 1'b1; flush_i = 1'b0;
    commit_i_valid = 1'b0; commit_rd = '0; commit_prd = '0;
    commit_old_prd = '0; commit_old_prd_valid = 1'b0;
    tick();
    check("rst_ready", 64'(si_i_ready), 64'd0);
    check("rst_valid", 64'(di_o_valid), 64'd0);
    check("rst_di_zero", 64'(di_o == '0), 64'd1);
    check("rst_count", 64'(dut.fl_count_q), 64'd64);

    // 1: addi x5,x0,1 then add x6,x5,x5
    do_reset();
    si_i = mk_si(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); si_i_valid = 1'b1;
    #1 check("t1_ready", 64'(si_i_ready), 64'd1);
    tick();
    check("t1_valid", 64'(di_o_valid), 64'd1);
    check("t1_prd", 64'(f_prd()), 64'd0);
    check("t1_opv", 64'(di_o[D_OPV]), 64'd0);
    check("t1_id", 64'(f_id()), 64'd0);
    check("t1_r1", 64'(di_o[D_R1]), 64'd0);
    si_i = mk_si(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    check("t1b_prs1", 64'(f_prs1()), 64'd0);
    check("t1b_prs2", 64'(f_prs2()), 64'd0);
    check("t1b_r1", 64'(di_o[D_R1]), 64'd1);
    check("t1b_r2", 64'(di_o[D_R2]), 64'd1);
    check("t1b_prd", 64'(f_prd()), 64'd1);
    check("t1b_id", 64'(f_id()), 64'd1);
    si_i_valid = 1'b0;
    tick();
    check("t1_drain", 64'(di_o_valid), 64'd0);

    // 2: two writes to x7, commit of the second frees the first
    do_reset();
    si_i = mk_si(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); si_i_valid = 1'b1;
    tick();
    check("t2_prd0", 64'(f_prd()), 64'd0);
    tick();
    check("t2_prd1", 64'(f_prd()), 64'd1);
    check("t2_old", 64'(f_oprd()), 64'd0);
    check("t2_opv", 64'(di_o[D_OPV]), 64'd1);
    si_i_valid = 1'b0;
    check("t2_cnt62", 64'(dut.fl_count_q), 64'd62);
    commit_i_valid = 1'b1; commit_rd = 5'd7; commit_prd = 6'd1;
    commit_old_prd = 6'd0; commit_old_prd_valid = 1'b1;
    tick();
    commit_i_valid = 1'b0; commit_old_prd_valid = 1'b0;
    check("t2_cnt63", 64'(dut.fl_count_q), 64'd63);
    check("t2_rat7", 64'(dut.rat_ren_q[7]), 64'd0);
    si_i = mk_si(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); si_i_valid = 1'b1;
    tick();
    si_i_valid = 1'b0;
    check("t2_read_r1", 64'(di_o[D_R1]), 64'd0);
    check("t2_read_prd", 64'(f_prd()), 64'd0);

    // 3: drain the free list, stall, then resume with the freed id
    do_reset();
    si_i_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      si_i = mk_si(5'd0, 1'b0, 5'd0, 1'b0, 5'((i % 31) + 1), 1'b1, 1'b0);
      tick();
      check("t3_prd", 64'(f_prd()), 64'(i));
    end
    si_i = mk_si(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    #1 check("t3_stall", 64'(si_i_ready), 64'd0);
    tick();
    check("t3_nofire", 64'(di_o_valid), 64'd0);
    check("t3_cnt0", 64'(dut.fl_count_q), 64'd0);
    commit_i_valid = 1'b1; commit_rd = 5'd3; commit_prd = 6'd0;
    commit_old_prd = 6'd37; commit_old_prd_valid = 1'b1;
    #1 check("t3_stall_push", 64'(si_i_ready), 64'd0);
    tick();
    commit_i_valid = 1'b0; commit_old_prd_valid = 1'b0;
    check("t3_cnt1", 64'(dut.fl_count_q), 64'd1);
    #1 check("t3_ready", 64'(si_i_ready), 64'd1);
    tick();
    si_i_valid = 1'b0;
    check("t3_prd_freed", 64'(f_prd()), 64'd37);
    check("t3_old", 64'(f_oprd()), 64'd39);
    check("t3_opv", 64'(di_o[D_OPV]), 64'd1);
    check("t3_cnt_end", 64'(dut.fl_count_q), 64'd0);

    // 4: downstream back-pressure holds the output slot
    do_reset();
    si_i = mk_si(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); si_i_valid = 1'b1;
    tick();
    check("t4_prd", 64'(f_prd()), 64'd0);
    held = di_o;
    di_i_ready = 1'b0;
    si_i = mk_si(5'd4, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_ready", 64'(si_i_ready), 64'd0);
      tick();
      check("t4_hold", 64'(di_o == held), 64'd1);
      check("t4_valid", 64'(di_o_valid), 64'd1);
      check("t4_cnt", 64'(dut.fl_count_q), 64'd63);
      check("t4_id", 64'(dut.id_q), 64'd1);
    end
    di_i_ready = 1'b1;
    tick();
    si_i_valid = 1'b0;
    check("t4_next_prd", 64'(f_prd()), 64'd1);
    check("t4_next_id", 64'(f_id()), 64'd1);
    check("t4_next_r1", 64'(di_o[D_R1]), 64'd1);

    // 5: flush with 10 pregs allocated and a valid output
    do_reset();
    si_i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      si_i = mk_si(5'd0, 1'b0, 5'd0, 1'b0, 5'(i + 1), 1'b1, 1'b0);
      tick();
    end
    check("t5_cnt54", 64'(dut.fl_count_q), 64'd54);
    check("t5_valid", 64'(di_o_valid), 64'd1);
    flush_i = 1'b1;
    #1 check("t5_flush_ready", 64'(si_i_ready), 64'd0);
    tick();
    flush_i = 1'b0;
    check("t5_valid0", 64'(di_o_valid), 64'd0);
    check("t5_cnt64", 64'(dut.fl_count_q), 64'd64);
    si_i = mk_si(5'd3, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 1'b0);
    tick();
    si_i_valid = 1'b0;
    check("t5_r1", 64'(di_o[D_R1]), 64'd0);
    check("t5_r2", 64'(di_o[D_R2]), 64'd0);
    check("t5_prd", 64'(f_prd()), 64'd0);
    check("t5_id", 64'(f_id()), 64'd10);

    // 6: rd=0 allocates nothing; add x3,x3,x4 reads the pre-update x3 mapping
    do_reset();
    si_i = mk_si(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); si_i_valid = 1'b1;
    tick();
    si_i = mk_si(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    check("t6_x0_prd", 64'(f_prd()), 64'd0);
    check("t6_x0_opv", 64'(di_o[D_OPV]), 64'd0);
    check("t6_x0_cnt", 64'(dut.fl_count_q), 64'd63);
    si_i = mk_si(5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    check("t6_prd", 64'(f_prd()), 64'd1);
    check("t6_old", 64'(f_oprd()), 64'd0);
    check("t6_opv", 64'(di_o[D_OPV]), 64'd1);
    check("t6_prs1", 64'(f_prs1()), 64'd0);
    check("t6_r1", 64'(di_o[D_R1]), 64'd1);
    check("t6_r2", 64'(di_o[D_R2]), 64'd0);
    si_i = mk_si(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    si_i_valid = 1'b0;
    check("t6_uimm_r1", 64'(di_o[D_R1]), 64'd0);
    check("t6_uimm_prs1", 64'(f_prs1()), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rename.md
Name: rename

Overview:
- Single-issue register-rename stage between decode and the issue/execute-writeback stage.
- Maps architectural destinations to physical registers drawn from a free list. Tags each source as renamed (operand read from PRF + scoreboard) or not renamed (operand read from ARF).
- Assigns sequence ids and presents one registered di_t per cycle downstream.
- Reclaims physical registers on commit and restores a clean mapping on flush.

Parameters:
- ARFSIZE, 32, number of architectural registers; x0 is never renamed.
- PRFSIZE, 64, number of physical registers; the free list holds up to PRFSIZE entries.
- ID_BITS, 16, width of the sequence id counter; wraps modulo 2^ID_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- si_i  in  si_t  decoded instruction: pc, fu, op, rs1, rs2, rs1_valid, rs2_valid, rd, rd_valid, imm, use_uimm
- si_i_valid  in  1  decode holds a valid instruction
- si_i_ready  out  1  rename accepts si_i this cycle
- di_o  out  di_t  renamed instruction: si, id, prs1, prs2, prs1_renammed, prs2_renammed, prd, old_prd, old_prd_valid
- di_o_valid  out  1  output register holds a valid instruction
- di_i_ready  in  1  downstream consumes di_o this cycle
- commit_i_valid  in  1  one instruction commits this cycle
- commit_rd  in  log2(ARFSIZE)  architectural destination of the committing instruction
- commit_prd  in  log2(PRFSIZE)  physical destination of the committing instruction
- commit_old_prd  in  log2(PRFSIZE)  previous mapping to free
- commit_old_prd_valid  in  1  commit_old_prd is to be freed
- flush_i  in  1  squash all in-flight instructions; ARF holds committed state

Behaviour:
- State:
  - RAT: ARFSIZE entries of {preg, renamed}.
  - Free list: circular FIFO of PRFSIZE preg ids with head, tail and count.
  - One-entry output register.
  - id counter.
- Reset (async, rst=1):
  - All RAT entries renamed=0, preg=0.
  - Free list full: count=PRFSIZE, entries 0..PRFSIZE-1 in order, head=0.
  - id=0, di_o_valid=0, di_o all zero.
  - si_i_ready=0 while rst is asserted.
- Allocation need:
  - need_alloc = rd_valid && rd!=0.
  - stall_fl = need_alloc && count==0.
- Handshake:
  - si_i_ready = !stall_fl && (!di_o_valid || di_i_ready) && !flush_i.
  - fire = si_i_valid && si_i_ready.
- Latency: 1 cycle. On fire, di_o is registered next edge, di_o_valid=1, id increments by 1. If di_o_valid && di_i_ready && !fire, then di_o_valid goes to 0. di_o is held stable while di_o_valid && !di_i_ready.
- Source lookup (combinational from current RAT):
  - prsX = RAT[rsX].preg.
  - prsX_renammed = RAT[rsX].renamed && rsX_valid && !(X==1 && use_uimm).
  - rsX==0 always gives renamed=0.
- Destination, on fire with need_alloc:
  - prd = free-list head; pop.
  - old_prd = RAT[rd].preg; old_prd_valid = RAT[rd].renamed.
  - RAT[rd] <= {prd,1}.
  - Without need_alloc: prd=0, old_prd_valid=0, no RAT write.
- Same-instruction hazard: rs1==rd or rs2==rd reads the pre-update mapping.
- Commit:
  - If commit_old_prd_valid, push commit_old_prd to the tail.
  - If RAT[commit_rd]=={commit_prd,1}, clear its renamed bit; the value now lives in the ARF.
  - commit_prd is not freed here; it is freed when the next writer of rd commits.
- Simultaneous events:
  - Pop + push same cycle: count unchanged. Push with count==0 is legal; the pushed entry is not poppable until the next cycle.
  - Rename write and commit clear to the same areg in the same cycle: the rename write wins.
  - count must never exceed PRFSIZE; an assertion fires on overflow.
- Flush (sync, priority over fire and commit):
  - di_o_valid <= 0.
  - All RAT renamed bits <= 0.
  - Free list restored to full: count=PRFSIZE, head/tail reset, entries 0..PRFSIZE-1.
  - id counter is not reset.
- Wrap-around: head and tail wrap modulo PRFSIZE; id wraps modulo 2^ID_BITS.

Test Plan:
1. Reset, then rename addi x5,x0,1 with rd=5 -> di_o next cycle: prd=0, old_prd_valid=0, id=0, prs1_renammed=0. Then add x6,x5,x5 -> prs1=prs2=0, both renamed=1, prd=1.
2. Two writes to x7 (prd 0 then 1), then commit {rd=7, prd=1, old_prd=0, valid=1} -> count returns from 62 to 63, RAT[7] renamed=0, and a following read of x7 gives renamed=0.
3. 64 back-to-back writers with no commits -> the 65th stalls with si_i_ready=0. Commit one old_prd -> the 65th fires the next cycle with prd equal to the freed id.
4. di_i_ready=0 for 3 cycles with si_i_valid=1 -> di_o is held stable, si_i_ready=0, no pops, id not incremented.
5. Flush while di_o_valid=1 and 10 pregs allocated -> next cycle di_o_valid=0, count=64, all sources read renamed=0, and the next rename gets prd=0.
6. rd=0, and add x3,x3,x4 with x3 already renamed -> rd=0 allocates nothing. The add gets old_prd = previous x3 mapping and prs1 = that same old mapping.
